// File: rtl/gate_op_pkg.sv
// rtl/gate_op_pkg.sv - op codes and shared types for the gate op scheduler
package gate_op_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
    localparam logic [OP_W-1:0] OP_AND  = 3'd1;
    localparam logic [OP_W-1:0] OP_OR   = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_BUF  = 3'd7;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - combinational bitwise gate selected by op code
module logic_gate_unit
    import gate_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Op table; b is a don't-care for NOT and BUF
    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_BUF:  y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/gate_op_scheduler.sv
// rtl/gate_op_scheduler.sv - round-robin sharing of one gate unit; optional grant counter via GATE_OP_SCHEDULER_STATS_EN
module gate_op_scheduler
    import gate_op_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*OP_W-1:0]  req_op,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
`ifdef GATE_OP_SCHEDULER_STATS_EN
    output logic [15:0]              grant_count,
`endif
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [IDW-1:0]           res_id,
    output logic [OP_W-1:0]          res_op
);

    out_state_t         state;
    logic [IDW-1:0]     ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     gnt_idx;
    logic               found;
    logic               accept;
    logic               xfer;
    logic [OP_W-1:0]    sel_op;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   gate_y;

    logic [OP_W-1:0]    op_arr [NUM_REQ];
    logic [WIDTH-1:0]   a_arr  [NUM_REQ];
    logic [WIDTH-1:0]   b_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_arr[gi] = req_op[gi*OP_W +: OP_W];
        assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
        assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
    end

    // Round-robin pick: first valid requester at or after ptr, wrapping
    always_comb begin : arb
        logic [IDW-1:0] idx;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

    assign res_valid = (state == ST_FULL);
    assign accept    = !res_valid || res_ready;
    // Ready is forced low while reset is held so nothing looks accepted
    assign req_ready = (rst_n && accept) ? grant : '0;
    assign xfer      = |req_ready;

    assign sel_op = op_arr[gnt_idx];
    assign sel_a  = a_arr[gnt_idx];
    assign sel_b  = b_arr[gnt_idx];

    logic_gate_unit #(.WIDTH(WIDTH)) u_gate (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (gate_y)
    );

    // Output register: capture on transfer, drain when consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            res_data <= '0;
            res_id   <= '0;
            res_op   <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            state    <= ST_FULL;
            res_data <= gate_y;
            res_id   <= gnt_idx;
            res_op   <= sel_op;
            ptr      <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end else if (res_ready) begin
            state    <= ST_EMPTY;
        end
    end

`ifdef GATE_OP_SCHEDULER_STATS_EN
    // Saturating count of accepted requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_count <= '0;
        end else if (xfer && grant_count != 16'hFFFF) begin
            grant_count <= grant_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gate_op_scheduler.sv
// tb/tb_gate_op_scheduler.sv - self-checking bench for gate_op_scheduler
module tb_gate_op_scheduler;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int IDW     = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*3-1:0]     req_op;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_data;
    logic [IDW-1:0]           res_id;
    logic [2:0]               res_op;
`ifdef GATE_OP_SCHEDULER_STATS_EN
    logic [15:0]              grant_count;
`endif

    always #5 clk = ~clk;

    gate_op_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef GATE_OP_SCHEDULER_STATS_EN
        .grant_count(grant_count),
`endif
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_op     (res_op)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [IDW-1:0]   id;
        logic [2:0]       op;
    } exp_t;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;

    exp_t               sb[$];
    int                 gnt_log[$];
    int                 n_pass  = 0;
    int                 n_total = 0;
    logic               prev_xfer = 1'b0;
    logic [NUM_REQ-1:0] acc_last  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference gate via per-op truth table indexed by {a_bit, b_bit}
    function automatic logic [WIDTH-1:0] gate_model(input logic [2:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [3:0]       tt;
        logic [WIDTH-1:0] r;
        case (op)
            3'd0: tt = 4'b0011;
            3'd1: tt = 4'b1000;
            3'd2: tt = 4'b1110;
            3'd3: tt = 4'b0111;
            3'd4: tt = 4'b0001;
            3'd5: tt = 4'b0110;
            3'd6: tt = 4'b1001;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < WIDTH; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    // Monitor: pop/compare results, log grants and push expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_xfer) chk("latency_valid", {31'd0, res_valid}, 32'd1);
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_underflow: result id %0d data %0h with no expected entry", res_id, res_data);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_data", {24'd0, res_data}, {24'd0, e.data});
                        chk("sb_id", {30'd0, res_id}, {30'd0, e.id});
                        chk("sb_op", {29'd0, res_op}, {29'd0, e.op});
                    end
                end
                chk("ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
                prev_xfer = 1'b0;
                acc_last  = req_valid & req_ready;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        e.op   = req_op[i*3 +: 3];
                        e.data = gate_model(e.op, req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH]);
                        e.id   = IDW'(i);
                        sb.push_back(e);
                        gnt_log.push_back(i);
                        prev_xfer = 1'b1;
                    end
                end
            end else begin
                prev_xfer = 1'b0;
                acc_last  = '0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b0;
        sb.delete();
        gnt_log.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    vec_t tbl[8];
    int   rr_exp[12];

    initial begin
        tbl[0] = '{3'd0, 8'hA5, 8'h0F, 8'h5A};
        tbl[1] = '{3'd1, 8'hA5, 8'h0F, 8'h05};
        tbl[2] = '{3'd2, 8'hA5, 8'h0F, 8'hAF};
        tbl[3] = '{3'd3, 8'hA5, 8'h0F, 8'hFA};
        tbl[4] = '{3'd4, 8'hA5, 8'h0F, 8'h50};
        tbl[5] = '{3'd5, 8'hA5, 8'h0F, 8'hAA};
        tbl[6] = '{3'd6, 8'hA5, 8'h0F, 8'h55};
        tbl[7] = '{3'd7, 8'hA5, 8'h0F, 8'hA5};
        rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3, 0};

        // Reset with all requesters asking
        rst_n = 1'b0; req_valid = '1; res_ready = 1'b1;
        req_op = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {24'd0, res_data}, 32'd0);
        chk("rst_res_id", {30'd0, res_id}, 32'd0);
`ifdef GATE_OP_SCHEDULER_STATS_EN
        chk("rst_grant_count", {16'd0, grant_count}, 32'd0);
`endif
        @(posedge clk); #2; rst_n = 1'b1;
        @(negedge clk);
        chk("first_grant", {28'd0, req_ready}, 32'h1);
        @(posedge clk); #1; req_valid = '0;

        // Op table on requester 1, back-to-back
        for (int k = 0; k < 8; k++) begin
            req_valid        = 4'b0010;
            req_op[5:3]      = tbl[k].op;
            req_a[15:8]      = tbl[k].a;
            req_b[15:8]      = tbl[k].b;
            req_op[2:0]      = 3'($urandom);
            req_a[7:0]       = 8'($urandom);
            @(negedge clk);
            chk($sformatf("op%0d_ready", k), {28'd0, req_ready}, 32'h2);
            @(posedge clk); #1;
            chk($sformatf("op%0d_valid", k), {31'd0, res_valid}, 32'd1);
            chk($sformatf("op%0d_data", k), {24'd0, res_data}, {24'd0, tbl[k].exp});
            chk($sformatf("op%0d_id", k), {30'd0, res_id}, 32'd1);
            chk($sformatf("op%0d_code", k), {29'd0, res_op}, {29'd0, tbl[k].op});
        end
        req_valid = '0;

        // Round-robin order, then with requester 2 dropped
        do_reset();
        req_valid = 4'b1111; res_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1; req_valid = 4'b1011;
        repeat (4) @(posedge clk);
        #1; req_valid = '0;
        chk("rr_count", gnt_log.size(), 32'd12);
        for (int k = 0; k < 12 && k < gnt_log.size(); k++)
            chk($sformatf("rr_grant%0d", k), gnt_log[k], rr_exp[k]);

        // Backpressure: hold result, then back-to-back transfer
        req_valid = 4'b0100; req_op[8:6] = 3'd1; req_a[23:16] = 8'hFF; req_b[23:16] = 8'h3C;
        @(negedge clk);
        chk("bp_accept", {28'd0, req_ready}, 32'h4);
        @(posedge clk); #1;
        res_ready = 1'b0; req_op[8:6] = 3'd5; req_a[23:16] = 8'h11; req_b[23:16] = 8'h22;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_ready%0d", k), {28'd0, req_ready}, 32'd0);
            chk($sformatf("bp_hold_data%0d", k), {24'd0, res_data}, 32'h3C);
            chk($sformatf("bp_hold_valid%0d", k), {31'd0, res_valid}, 32'd1);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_b2b_ready", {28'd0, req_ready}, 32'h4);
        @(posedge clk); #1;
        chk("bp_b2b_data", {24'd0, res_data}, 32'h33);
        chk("bp_b2b_op", {29'd0, res_op}, 32'd5);
        req_valid = '0;
        @(posedge clk); #1;
        chk("bp_drain_valid", {31'd0, res_valid}, 32'd0);

        // Reset while a result is held
        req_valid = 4'b1000; req_op[11:9] = 3'd2; req_a[31:24] = 8'h10; req_b[31:24] = 8'h01; res_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        chk("mr_held_valid", {31'd0, res_valid}, 32'd1);
        chk("mr_held_data", {24'd0, res_data}, 32'h11);
        #2; rst_n = 1'b0;
        #1;
        chk("mr_async_valid", {31'd0, res_valid}, 32'd0);
        chk("mr_async_data", {24'd0, res_data}, 32'd0);
        sb.delete();
        @(posedge clk); #2;
        rst_n = 1'b1; req_valid = 4'b1111; res_ready = 1'b1;
        @(negedge clk);
        chk("mr_ptr0", {28'd0, req_ready}, 32'h1);
        @(posedge clk); #1; req_valid = '0;

        // Random traffic against the scoreboard
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || acc_last[i]) begin
                    req_valid[i]           = ($urandom_range(0, 2) != 0);
                    req_op[i*3 +: 3]       = 3'($urandom);
                    req_a[i*WIDTH +: WIDTH] = 8'($urandom);
                    req_b[i*WIDTH +: WIDTH] = 8'($urandom);
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        req_valid = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

`ifdef GATE_OP_SCHEDULER_STATS_EN
        do_reset();
        req_valid = 4'b0001; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("gc_three", {16'd0, grant_count}, 32'd3);
        repeat (70000) @(posedge clk);
        #1;
        chk("gc_saturate", {16'd0, grant_count}, 32'hFFFF);
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("gc_hold", {16'd0, grant_count}, 32'hFFFF);
        chk("sb_drained_stats", sb.size(), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gate_op_scheduler.md
Name: gate_op_scheduler

Overview:
- Shares one combinational logic-gate unit among NUM_REQ requesters.
- Each requester issues an operation (op code plus operands a and b) using a valid/ready handshake.
- Grants are round-robin, one per cycle. Results are registered and returned on one output channel with valid/ready, tagged with the requester index.
- Sits between test/stimulus masters and the basic-gate datapath; it is the sequencing layer for every gate function the team has.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, operand/result bit width (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_op  in  NUM_REQ*3  op code per requester; requester i uses bits [3i+2:3i]
- req_a  in  NUM_REQ*WIDTH  operand a per requester, packed by index
- req_b  in  NUM_REQ*WIDTH  operand b per requester, packed by index
- res_valid  out  1  result valid
- res_ready  in  1  consumer accept
- res_data  out  WIDTH  gate result
- res_id  out  max(1,$clog2(NUM_REQ))  index of the requester that produced res_data
- res_op  out  3  op code that produced res_data

Behaviour:
- Op codes, applied bitwise:
  - 0 = NOT a
  - 1 = AND
  - 2 = OR
  - 3 = NAND
  - 4 = NOR
  - 5 = XOR
  - 6 = XNOR
  - 7 = BUF a
  - b is ignored for op 0 and op 7.
- accept = !res_valid || res_ready (combinational).
- Arbitration: the grant goes to the first i with req_valid[i], scanning from ptr upward and wrapping modulo NUM_REQ. req_ready[i] = accept && grant[i]. req_ready is all-zero when accept=0.
- Transfer on requester i = req_valid[i] && req_ready[i]. On the next edge:
  - res_data = gate(op,a,b)
  - res_id = i, res_op = op
  - res_valid = 1
  - ptr = (i+1) mod NUM_REQ
- Latency is exactly 1 cycle from transfer to res_valid.
- No transfer while res_valid && res_ready: res_valid clears on the next edge.
- Output state:
  - EMPTY (res_valid=0): moves to FULL on a transfer.
  - FULL (res_valid=1, payload stable): stays FULL on res_ready && new transfer (back-to-back, full throughput); goes to EMPTY on res_ready with no transfer; holds while res_ready=0.
- ptr does not change on cycles without a transfer.
- A single active requester gets a grant every cycle when the consumer is always ready.
- Requesters hold valid and payload until ready. The block does not check this.
- Reset (asynchronous assert, synchronous deassert handled upstream): res_valid=0, res_data=0, res_id=0, res_op=0, ptr=0. Reset mid-operation drops any held result. req_ready is 0 during reset.
- Simultaneous requests: exactly one grant. Starvation bound is NUM_REQ-1 grants to others.

Optional Feature:
- Macro: GATE_OP_SCHEDULER_STATS_EN.
- Defined: adds output grant_count [15:0].
  - Increments on every request transfer.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: port and counter absent. Behaviour otherwise identical.

Decomposition:
- Package gate_op_pkg holds:
  - op code localparams: OP_NOT=0, OP_AND=1, OP_OR=2, OP_NAND=3, OP_NOR=4, OP_XOR=5, OP_XNOR=6, OP_BUF=7
  - OP_W=3
- Sub-module logic_gate_unit: purely combinational, parameter WIDTH, ports op, a, b, y. It implements the op table and is instantiated once behind the arbiter mux.
- Round-robin arbitration stays inline.

Test Plan:
- Reset: hold rst_n=0 with req_valid=4'b1111 -> req_ready=0, res_valid=0, res_data=0. Release; first grant goes to requester 0.
- Op table: requester 1 only, WIDTH=8, a=8'hA5, b=8'h0F, ops 0..7 in turn with res_ready=1 -> res_data = 5A, 05, AF, FA, 50, AA, 55, A5. Each appears 1 cycle after transfer with res_id=1.
- Round-robin: all four valid, res_ready=1 -> grant order 0,1,2,3,0,…, one per cycle. Drop req 2 -> order becomes 0,1,3,0.
- Backpressure: res_ready=0 for 5 cycles with result op 1, a=FF, b=3C -> res_data=3C held stable, req_ready=0. res_ready=1 with a pending request -> back-to-back transfer, no bubble.
- Reset mid-operation: res_valid=1 holding data, assert rst_n=0 asynchronously -> res_valid drops immediately. After release, ptr=0.
- Stats (macro defined): 70000 transfers -> grant_count=16'hFFFF, no wrap.
